// File: rtl/semaforo_ctrl.sv
// Round-robin traffic-light controller for N_WAYS approaches with min/max green timing.
// Optional pedestrian walk phase is enabled by defining SEMAFORO_PED_EN.
`timescale 1ns/1ps
module semaforo_ctrl #(
  parameter int N_WAYS     = 2,
  parameter int MIN_GREEN  = 4,
  parameter int MAX_GREEN  = 10,
  parameter int YELLOW_CYC = 2,
  parameter int ALLRED_CYC = 1,
  parameter int WALK_CYC   = 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_WAYS-1:0]         req,
  output logic [N_WAYS-1:0]         green,
  output logic [N_WAYS-1:0]         yellow,
  output logic [N_WAYS-1:0]         red,
  output logic [$clog2(N_WAYS)-1:0] active
`ifdef SEMAFORO_PED_EN
  ,
  input  logic                      ped_req,
  output logic                      walk
`endif
);

  localparam int AW      = $clog2(N_WAYS);
  localparam int CNT_MAX = (MAX_GREEN > WALK_CYC) ? MAX_GREEN : WALK_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] LD_ALLRED = CW'(ALLRED_CYC);
  localparam logic [CW-1:0] LD_GREEN  = CW'(MAX_GREEN);
  localparam logic [CW-1:0] LD_YELLOW = CW'(YELLOW_CYC);
  // GREEN counts down from MAX_GREEN, so MIN_GREEN elapsed cycles correspond to this value.
  localparam logic [CW-1:0] MIN_MARK  = CW'(MAX_GREEN - MIN_GREEN + 1);
`ifdef SEMAFORO_PED_EN
  localparam logic [CW-1:0] LD_WALK   = CW'(WALK_CYC);
`endif

`ifdef SEMAFORO_PED_EN
  typedef enum logic [1:0] {S_ALLRED, S_GREEN, S_YELLOW, S_WALK} state_t;
`else
  typedef enum logic [1:0] {S_ALLRED, S_GREEN, S_YELLOW} state_t;
`endif

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [AW-1:0]     active_q, active_d;
  logic [AW-1:0]     ptr_q, ptr_d;
  logic [N_WAYS-1:0] pend_q, pend_d;
  logic [N_WAYS-1:0] green_q, green_d;
  logic [N_WAYS-1:0] yellow_q, yellow_d;
  logic [N_WAYS-1:0] red_q, red_d;
`ifdef SEMAFORO_PED_EN
  logic              ped_pend_q, ped_pend_d;
  logic              walk_q, walk_d;
  logic              ped_eff;
`endif

  logic [N_WAYS-1:0] active_mask;
  logic [N_WAYS-1:0] pend_eff;
  logic [N_WAYS-1:0] other_pend;
  logic [N_WAYS-1:0] pend_rot;
  logic              lamp_busy;
  logic              cnt_done;
  logic              min_done;
  logic              grant_vld;
  logic [AW-1:0]     grant_off;
  logic [AW:0]       grant_sum;
  logic [AW-1:0]     grant_idx;
  logic [AW-1:0]     ptr_next;

  // A request seen this cycle counts immediately so the decision does not lag a cycle.
  always_comb begin
    active_mask           = '0;
    active_mask[active_q] = 1'b1;
    lamp_busy             = (state_q == S_GREEN) || (state_q == S_YELLOW);
    pend_eff              = pend_q | req;
    other_pend            = pend_eff & ~active_mask;
    cnt_done              = (cnt_q == CW'(1));
    min_done              = (cnt_q <= MIN_MARK);
    ptr_next              = (active_q == AW'(N_WAYS - 1)) ? '0 : active_q + 1'b1;
  end

  // Rotate so bit 0 is ptr, then the lowest set bit is the round-robin winner.
  always_comb begin
    pend_rot  = N_WAYS'({pend_eff, pend_eff} >> ptr_q);
    grant_vld = 1'b0;
    grant_off = '0;
    for (int k = N_WAYS - 1; k >= 0; k--) begin
      if (pend_rot[k]) begin
        grant_vld = 1'b1;
        grant_off = AW'(k);
      end
    end
    grant_sum = {1'b0, ptr_q} + {1'b0, grant_off};
    grant_idx = (grant_sum >= (AW+1)'(N_WAYS)) ? AW'(grant_sum - (AW+1)'(N_WAYS))
                                               : AW'(grant_sum);
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    ptr_d    = ptr_q;
    pend_d   = pend_q | (req & ~(lamp_busy ? active_mask : '0));
`ifdef SEMAFORO_PED_EN
    ped_eff    = ped_pend_q | ped_req;
    ped_pend_d = ped_eff;
`endif
    unique case (state_q)
      S_ALLRED: begin
        if (!cnt_done) begin
          cnt_d = cnt_q - 1'b1;
`ifdef SEMAFORO_PED_EN
        end else if (ped_eff) begin
          state_d    = S_WALK;
          cnt_d      = LD_WALK;
          ped_pend_d = 1'b0;
`endif
        end else if (grant_vld) begin
          state_d           = S_GREEN;
          cnt_d             = LD_GREEN;
          active_d          = grant_idx;
          pend_d[grant_idx] = 1'b0;
        end
      end
      S_GREEN: begin
        if (cnt_done || (min_done && (|other_pend))) begin
          state_d = S_YELLOW;
          cnt_d   = LD_YELLOW;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_YELLOW: begin
        if (cnt_done) begin
          state_d = S_ALLRED;
          cnt_d   = LD_ALLRED;
          ptr_d   = ptr_next;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`ifdef SEMAFORO_PED_EN
      S_WALK: begin
        if (cnt_done) begin
          state_d = S_ALLRED;
          cnt_d   = LD_ALLRED;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
`endif
      default: begin
        state_d = S_ALLRED;
        cnt_d   = LD_ALLRED;
      end
    endcase
  end

  // Lamps are decoded from the next state so they register in step with it.
  always_comb begin
    green_d  = '0;
    yellow_d = '0;
    red_d    = '1;
    if (state_d == S_GREEN) begin
      green_d[active_d] = 1'b1;
      red_d[active_d]   = 1'b0;
    end else if (state_d == S_YELLOW) begin
      yellow_d[active_d] = 1'b1;
      red_d[active_d]    = 1'b0;
    end
`ifdef SEMAFORO_PED_EN
    walk_d = (state_d == S_WALK);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_ALLRED;
      cnt_q      <= LD_ALLRED;
      active_q   <= '0;
      ptr_q      <= '0;
      pend_q     <= '0;
      green_q    <= '0;
      yellow_q   <= '0;
      red_q      <= '1;
`ifdef SEMAFORO_PED_EN
      ped_pend_q <= 1'b0;
      walk_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      active_q   <= active_d;
      ptr_q      <= ptr_d;
      pend_q     <= pend_d;
      green_q    <= green_d;
      yellow_q   <= yellow_d;
      red_q      <= red_d;
`ifdef SEMAFORO_PED_EN
      ped_pend_q <= ped_pend_d;
      walk_q     <= walk_d;
`endif
    end
  end

  assign green  = green_q;
  assign yellow = yellow_q;
  assign red    = red_q;
  assign active = active_q;
`ifdef SEMAFORO_PED_EN
  assign walk   = walk_q;
`endif

endmodule

// File: tb/tb_semaforo_ctrl.sv
// Directed self-checking bench for semaforo_ctrl at default parameters (N_WAYS=2).
`timescale 1ns/1ps
module tb_semaforo_ctrl;

  logic       clk;
  logic       rst_n;
  logic [1:0] req;
  logic [1:0] green;
  logic [1:0] yellow;
  logic [1:0] red;
  logic [0:0] active;
`ifdef SEMAFORO_PED_EN
  logic       ped_req;
  logic       walk;
`endif

  int n_err;
  int n_chk;

  // Lamp vector packed as {green, yellow, red}.
  localparam logic [5:0] RR = 6'b00_00_11;
  localparam logic [5:0] G0 = 6'b01_00_10;
  localparam logic [5:0] G1 = 6'b10_00_01;
  localparam logic [5:0] Y0 = 6'b00_01_10;
  localparam logic [5:0] Y1 = 6'b00_10_01;

  semaforo_ctrl dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .green  (green),
    .yellow (yellow),
    .red    (red),
    .active (active)
`ifdef SEMAFORO_PED_EN
    ,
    .ped_req(ped_req),
    .walk   (walk)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input string tag, input logic [5:0] exp_l, input logic exp_a, input int n);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_lamp%0d", tag, i), {26'd0, green, yellow, red}, {26'd0, exp_l});
      check($sformatf("%s_act%0d", tag, i), {31'd0, active}, {31'd0, exp_a});
      step();
    end
  endtask

  // Reset takes effect without waiting for a clock edge.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check({tag, "_rst_lamp"}, {26'd0, green, yellow, red}, {26'd0, RR});
    check({tag, "_rst_act"}, {31'd0, active}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    clk   = 1'b0;
    rst_n = 1'b1;
    req   = 2'b00;
    n_err = 0;
    n_chk = 0;
`ifdef SEMAFORO_PED_EN
    ped_req = 1'b0;
`endif
    #2;
    do_reset("init");

    // Idle after reset: all red, nothing granted.
    run("idle", RR, 1'b0, 5);

    // Single pulse on approach 0: full MAX_GREEN, yellow, then idle.
    req = 2'b01;
    step();
    req = 2'b00;
    run("pulse_g0", G0, 1'b0, 10);
    run("pulse_y0", Y0, 1'b0, 2);
    run("pulse_idle", RR, 1'b0, 4);

    // Both requests held: alternate at MIN_GREEN.
    do_reset("alt");
    req = 2'b11;
    step();
    run("alt_g0a", G0, 1'b0, 4);
    run("alt_y0a", Y0, 1'b0, 2);
    run("alt_ra", RR, 1'b0, 1);
    run("alt_g1", G1, 1'b1, 4);
    run("alt_y1", Y1, 1'b1, 2);
    run("alt_rb", RR, 1'b1, 1);
    run("alt_g0b", G0, 1'b0, 4);
    req = 2'b00;

    // Request for approach 1 in green cycle 7 of approach 0 ends green after that cycle.
    do_reset("late");
    req = 2'b01;
    step();
    req = 2'b00;
    run("late_g0", G0, 1'b0, 6);
    req = 2'b10;
    run("late_g0c7", G0, 1'b0, 1);
    req = 2'b00;
    run("late_y0", Y0, 1'b0, 2);
    run("late_r", RR, 1'b0, 1);
    run("late_g1", G1, 1'b1, 10);
    check("late_y1_entry", {26'd0, green, yellow, red}, {26'd0, Y1});

    // Reset during yellow of approach 1: immediate all-red, pending gone.
    do_reset("midy");
    run("midy_idle", RR, 1'b0, 6);

`ifdef SEMAFORO_PED_EN
    // Pedestrian and vehicle together: walk first, then vehicle green.
    do_reset("ped");
    req     = 2'b01;
    ped_req = 1'b1;
    step();
    req     = 2'b00;
    ped_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("ped_walk%0d", i), {31'd0, walk}, 32'd1);
      check($sformatf("ped_lamp%0d", i), {26'd0, green, yellow, red}, {26'd0, RR});
      step();
    end
    check("ped_ar_walk", {31'd0, walk}, 32'd0);
    check("ped_ar_lamp", {26'd0, green, yellow, red}, {26'd0, RR});
    step();
    check("ped_g0_walk", {31'd0, walk}, 32'd0);
    check("ped_g0_lamp", {26'd0, green, yellow, red}, {26'd0, G0});
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/semaforo_ctrl.md
SEMAFORO_CTRL -- requirements
Module: semaforo_ctrl

Interface
REQ-001 Parameter N_WAYS, default 2: number of approaches; legal range 2..8.
REQ-002 Parameter MIN_GREEN, default 4: minimum green duration in cycles; must be >= 1.
REQ-003 Parameter MAX_GREEN, default 10: maximum green duration in cycles; must be >= MIN_GREEN.
REQ-004 Parameter YELLOW_CYC, default 2: yellow duration in cycles; must be >= 1.
REQ-005 Parameter ALLRED_CYC, default 1: all-red clearance duration in cycles; must be >= 1.
REQ-006 Parameter WALK_CYC, default 6: pedestrian walk duration in cycles; used only with SEMAFORO_PED_EN.
REQ-007 clk  input  1  single clock; all state updates on the rising edge.
REQ-008 rst_n  input  1  reset, asynchronous, active-low.
REQ-009 req  input  N_WAYS  per-approach vehicle sensor; level or pulse; sampled every cycle.
REQ-010 green  output  N_WAYS  per-approach green lamp; registered.
REQ-011 yellow  output  N_WAYS  per-approach yellow lamp; registered.
REQ-012 red  output  N_WAYS  per-approach red lamp; registered.
REQ-013 active  output  clog2(N_WAYS)  index of the approach currently green or yellow; holds its last value otherwise.
REQ-014 ped_req  input  1  pedestrian button; present only when SEMAFORO_PED_EN is defined.
REQ-015 walk  output  1  pedestrian walk lamp; registered; present only when SEMAFORO_PED_EN is defined.

Function
REQ-016 FSM states: ALLRED, GREEN, YELLOW, and WALK (WALK only with SEMAFORO_PED_EN).
REQ-017 For every approach i, exactly one of green[i], yellow[i], red[i] is high in every cycle; at most one approach is non-red.
REQ-018 pending[i] is set when req[i]=1, except while approach i is green or yellow; a request from the active approach is ignored.
REQ-019 pending[i] is cleared on the cycle approach i enters GREEN; if set and clear coincide, clear wins.
REQ-020 ALLRED: all lamps red for exactly ALLRED_CYC cycles; the machine then stays in ALLRED, red, until any pending bit is set.
REQ-021 Grant: at ALLRED exit, select the first pending approach searching from ptr upward with wrap-around (ptr, ptr+1, ..., N_WAYS-1, 0, ...); enter GREEN with active set to that index.
REQ-022 GREEN lasts at least MIN_GREEN cycles and at most MAX_GREEN cycles.
REQ-023 After MIN_GREEN cycles, GREEN ends on the first cycle in which some other approach is pending; otherwise it extends until MAX_GREEN.
REQ-024 If no other approach is pending at MAX_GREEN, GREEN still ends.
REQ-025 YELLOW lasts exactly YELLOW_CYC cycles, then the machine enters ALLRED with ptr = (active+1) mod N_WAYS.
REQ-026 The cycle counter is sized clog2(max(MAX_GREEN, WALK_CYC)+1); it reloads on every state entry and never wraps.
REQ-027 req changes have no effect on lamp outputs within the same cycle; the earliest lamp response is the next rising edge.

Reset
REQ-028 While rst_n=0, asynchronously: state=ALLRED, counter reloaded with ALLRED_CYC, red all 1, green and yellow all 0, active=0, ptr=0, pending all 0, walk=0.
REQ-029 Reset asserted mid-GREEN or mid-YELLOW forces all-red immediately, without a yellow phase.
REQ-030 After rst_n deasserts, the first ALLRED interval lasts a full ALLRED_CYC cycles.

Configuration
REQ-031 Macro SEMAFORO_PED_EN defined: ped_req is latched into ped_pending.
REQ-032 At ALLRED exit, ped_pending takes priority over vehicle pending bits and the machine enters WALK.
REQ-033 WALK: all vehicle lamps red, walk=1 for exactly WALK_CYC cycles, ped_pending cleared on entry, then ALLRED with ptr unchanged.
REQ-034 Macro SEMAFORO_PED_EN undefined: no ped_req or walk ports, no WALK state; behaviour is otherwise identical.

Verification (N_WAYS=2, MIN_GREEN=4, MAX_GREEN=10, YELLOW_CYC=2, ALLRED_CYC=1 unless noted)
REQ-035 Reset released, no req -> red=2'b11 indefinitely; green=0; active=0.
REQ-036 One-cycle pulse req=2'b01 -> green[0] high for 10 cycles, yellow[0] 2 cycles, then red=2'b11 and the machine idles.
REQ-037 req=2'b11 held -> green alternates 0,1,0,1 with 4 green, 2 yellow, 1 all-red cycles each; never two non-red approaches in the same cycle.
REQ-038 req[1] pulsed on cycle 7 of green[0] -> green[0] ends after cycle 7, followed by 2 yellow, 1 all-red, then green[1].
REQ-039 rst_n pulled low during yellow[1] -> red=2'b11 the same cycle; pending cleared; no green until a new req.
REQ-040 SEMAFORO_PED_EN, WALK_CYC=6: ped_req and req[0] pulsed together while idle -> walk=1 for 6 cycles, 1 all-red cycle, then green[0].
